pipelined_adder: RTL and testbench

Parametrised successor to the four-bit ripple-carry adder. It is a WIDTH-bit add/subtract unit split into STAGES registered carry-ripple slices, with a valid/ready handshake on both sides. It sits between operand producers and result consumers in datapaths where a full-width ripple chain would miss timing. It accepts one operation per cycle when the consumer is ready.

---
 rtl/pipelined_adder.sv | 138 +++++++++++++
 tb/tb_pipelined_adder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_adder
//  Purpose  : WIDTH-bit add/subtract unit split into STAGES registered
//             carry-ripple slices with a valid/ready handshake on both sides.
//             Stage k adds slice k of A and B' (B' = sub ? ~B : B) plus the
//             carry registered by stage k-1. Operands not yet consumed travel
//             down the pipe alongside the partial sum (skewed delay).
//  Ports    : clock, reset         - clock, synchronous active-high reset
//             io_in_valid/ready    - input handshake
//             io_in_A/B/Cin/sub    - operands, carry-in, subtract select
//             io_out_valid/ready   - output handshake
//             io_out_Sum/Cout/Ovf  - result, carry out, signed overflow
//  Revision : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_A,
    input  logic [WIDTH-1:0] io_in_B,
    input  logic             io_in_Cin,
    input  logic             io_in_sub,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_Sum,
    output logic             io_out_Cout,
    output logic             io_out_Ovf
);

    localparam int CHUNK = WIDTH / STAGES;

    // Stage registers
    logic             r_valid [STAGES];
    logic [WIDTH-1:0] r_sum   [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic             r_carry [STAGES];
    logic             r_cmsb;              // carry into the MSB, last stage only

    // Next-state values produced by each slice
    logic             w_valid_nxt [STAGES];
    logic [WIDTH-1:0] w_sum_nxt   [STAGES];
    logic [WIDTH-1:0] w_a_nxt     [STAGES];
    logic [WIDTH-1:0] w_b_nxt     [STAGES];
    logic             w_carry_nxt [STAGES];
    logic             w_cmsb_nxt;

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;

    // Single global advance: the whole pipe moves or the whole pipe holds,
    // so bubbles travel with the data and are never collapsed.
    assign w_adv       = !r_valid[STAGES-1] || io_out_ready;
    assign io_in_ready = w_adv && !reset;

    // Subtraction is A + ~B + 1; Cin is ignored in that mode.
    assign w_b_eff   = io_in_sub ? ~io_in_B : io_in_B;
    assign w_cin_eff = io_in_sub | io_in_Cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] w_sa;
        logic [CHUNK-1:0] w_sb;
        logic             w_sc;
        logic [CHUNK:0]   w_res;
        logic [WIDTH-1:0] w_sum_base;
        logic [WIDTH-1:0] w_sum_loc;

        if (k == 0) begin : g_head
            assign w_sa           = io_in_A[CHUNK-1:0];
            assign w_sb           = w_b_eff[CHUNK-1:0];
            assign w_sc           = w_cin_eff;
            assign w_sum_base     = '0;
            assign w_valid_nxt[k] = io_in_valid;
            assign w_a_nxt[k]     = io_in_A;
            assign w_b_nxt[k]     = w_b_eff;
        end else begin : g_body
            assign w_sa           = r_a[k-1][k*CHUNK +: CHUNK];
            assign w_sb           = r_b[k-1][k*CHUNK +: CHUNK];
            assign w_sc           = r_carry[k-1];
            assign w_sum_base     = r_sum[k-1];
            assign w_valid_nxt[k] = r_valid[k-1];
            assign w_a_nxt[k]     = r_a[k-1];
            assign w_b_nxt[k]     = r_b[k-1];
        end

        assign w_res = {1'b0, w_sa} + {1'b0, w_sb} + {{CHUNK{1'b0}}, w_sc};

        // Lower slices come from the predecessor; this slice fills in its own bits.
        always_comb begin
            w_sum_loc                   = w_sum_base;
            w_sum_loc[k*CHUNK +: CHUNK] = w_res[CHUNK-1:0];
        end

        assign w_sum_nxt[k]   = w_sum_loc;
        assign w_carry_nxt[k] = w_res[CHUNK];

        if (k == STAGES - 1) begin : g_tail
            // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out
            // of the MSB sum bit without a separate short adder.
            assign w_cmsb_nxt = w_sa[CHUNK-1] ^ w_sb[CHUNK-1] ^ w_res[CHUNK-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                r_valid[i] <= 1'b0;
                r_sum[i]   <= '0;
                r_a[i]     <= '0;
                r_b[i]     <= '0;
                r_carry[i] <= 1'b0;
            end
            r_cmsb <= 1'b0;
        end else if (w_adv) begin
            for (int i = 0; i < STAGES; i++) begin
                r_valid[i] <= w_valid_nxt[i];
                r_sum[i]   <= w_sum_nxt[i];
                r_a[i]     <= w_a_nxt[i];
                r_b[i]     <= w_b_nxt[i];
                r_carry[i] <= w_carry_nxt[i];
            end
            r_cmsb <= w_cmsb_nxt;
        end
    end

    assign io_out_valid = r_valid[STAGES-1];
    assign io_out_Sum   = r_sum[STAGES-1];
    assign io_out_Cout  = r_carry[STAGES-1];
    assign io_out_Ovf   = r_cmsb ^ r_carry[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_adder
//  Purpose  : Self-checking bench for pipelined_adder (STAGES=4, plus
//             STAGES=1 and STAGES=16 instances sharing the input beat).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_ready;
    logic        ready_hi;

    logic        in_ready, out_valid, cout, ovf;
    logic [15:0] sum;
    logic        d1_in_ready, d1_valid, d1_cout, d1_ovf;
    logic [15:0] d1_sum;
    logic        d16_in_ready, d16_valid, d16_cout, d16_ovf;
    logic [15:0] d16_sum;

    logic [17:0] res_main, res_d1, res_d16;
    assign res_main = {ovf, cout, sum};
    assign res_d1   = {d1_ovf, d1_cout, d1_sum};
    assign res_d16  = {d16_ovf, d16_cout, d16_sum};

    int n_checks = 0;
    int n_errors = 0;

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(in_ready),
        .io_in_A(a), .io_in_B(b), .io_in_Cin(cin), .io_in_sub(sub),
        .io_out_valid(out_valid), .io_out_ready(out_ready),
        .io_out_Sum(sum), .io_out_Cout(cout), .io_out_Ovf(ovf)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(1)) dut_s1 (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(d1_in_ready),
        .io_in_A(a), .io_in_B(b), .io_in_Cin(cin), .io_in_sub(sub),
        .io_out_valid(d1_valid), .io_out_ready(ready_hi),
        .io_out_Sum(d1_sum), .io_out_Cout(d1_cout), .io_out_Ovf(d1_ovf)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(16)) dut_s16 (
        .clock(clock), .reset(reset),
        .io_in_valid(in_valid), .io_in_ready(d16_in_ready),
        .io_in_A(a), .io_in_B(b), .io_in_Cin(cin), .io_in_sub(sub),
        .io_out_valid(d16_valid), .io_out_ready(ready_hi),
        .io_out_Sum(d16_sum), .io_out_Cout(d16_cout), .io_out_Ovf(d16_ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: full 17-bit sum, signed overflow when both addends share a
    // sign and the result sign differs. Packed as {ovf, cout, sum}.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mcin, input logic msub);
        logic [15:0] bb;
        logic [16:0] full;
        logic        ov;
        bb   = msub ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + {16'd0, (msub | mcin)};
        ov   = (ma[15] == bb[15]) && (full[15] != ma[15]);
        return {ov, full};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One beat into an empty pipe, then count edges after acceptance until
    // the result appears on the STAGES=4 instance.
    task automatic single(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tcin, input logic tsub, input logic [17:0] exp);
        int cnt;
        in_valid = 1'b1; a = ta; b = tb_; cin = tcin; sub = tsub;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            step();
            cnt++;
        end
        check({tag, "_latency"}, cnt, 3);
        check({tag, "_result"}, 32'(res_main), 32'(exp));
    endtask

    logic [15:0] fa   [8] = '{16'h0001, 16'hFFFF, 16'h1234, 16'h8000,
                              16'h7FFF, 16'h00FF, 16'hAAAA, 16'h0000};
    logic [15:0] fb   [8] = '{16'h0002, 16'hFFFF, 16'h4321, 16'h8000,
                              16'h0001, 16'h0F01, 16'h5555, 16'h0000};
    logic        fcin [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        fsub [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        logic [17:0] q[$];
        logic [17:0] held;
        logic        held_valid;
        int sent, recv, cyc, leak, lat1, lat16;
        logic [17:0] r1, r16;

        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1; ready_hi = 1'b1;
        step(); step();
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_outputs",   32'(res_main),  32'd0);
        check("rst_s1_valid",  32'(d1_valid),  32'd0);
        check("rst_s16_valid", 32'(d16_valid), 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed arithmetic
        single("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h1_0000);
        single("sub_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 18'h3_7FFF);
        single("sub_borrow",  16'h0000, 16'h0001, 1'b0, 1'b1, 18'h0_FFFF);
        single("add_cin",     16'h7FFF, 16'h0001, 1'b1, 1'b0, 18'h2_8001);
        step();

        // Random streaming with backpressure
        sent = 0; recv = 0; cyc = 0; held_valid = 1'b0; held = '0;
        while (recv < 100 && cyc < 3000) begin
            if (held_valid) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold",  32'(res_main),  32'(held));
            end
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && !out_ready)
                check("stall_in_ready", 32'(in_ready), 32'd0);
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, cin, sub));
                sent++;
            end
            if (out_valid && out_ready) begin
                check("stream_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0)
                    check("stream_data", 32'(res_main), 32'(q.pop_front()));
                recv++;
            end
            held_valid = out_valid && !out_ready;
            held       = res_main;
            step();
            cyc++;
        end
        check("stream_count", recv, 100);
        check("stream_leftover", q.size(), 0);

        in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) step();

        // Full-rate: beat j appears in iteration 4+j
        for (int i = 0; i < 12; i++) begin
            if (i < 8) begin
                in_valid = 1'b1; a = fa[i]; b = fb[i]; cin = fcin[i]; sub = fsub[i];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (i < 8) check("full_in_ready", 32'(in_ready), 32'd1);
            if (i >= 4) begin
                check("full_valid", 32'(out_valid), 32'd1);
                check("full_data", 32'(res_main),
                      32'(model(fa[i-4], fb[i-4], fcin[i-4], fsub[i-4])));
            end else begin
                check("full_gap", 32'(out_valid), 32'd0);
            end
            step();
        end

        // Reset with three beats in flight
        in_valid = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 16'h1111 * 16'(i + 1); b = 16'h0101; cin = 1'b1; sub = 1'b0;
            step();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_in_ready_low", 32'(in_ready), 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_outputs",   32'(res_main),  32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        leak = 0;
        repeat (10) begin
            if (out_valid) leak++;
            step();
        end
        check("midrst_no_leak", leak, 0);

        // Parameter sweep on the STAGES=1 and STAGES=16 instances
        repeat (20) step();
        in_valid = 1'b1; a = 16'h7FFF; b = 16'h0001; cin = 1'b1; sub = 1'b0;
        step();
        in_valid = 1'b0;
        lat1 = -1; lat16 = -1; r1 = '0; r16 = '0;
        for (int k = 0; k < 25; k++) begin
            if (d1_valid && lat1 < 0) begin
                lat1 = k; r1 = res_d1;
            end
            if (d16_valid && lat16 < 0) begin
                lat16 = k; r16 = res_d16;
            end
            step();
        end
        check("s1_latency",  lat1,  0);
        check("s16_latency", lat16, 15);
        check("s1_result",   32'(r1),  32'h2_8001);
        check("s16_result",  32'(r16), 32'h2_8001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
